// File: rtl/pkg_irrigacao.sv
// Shared definitions for the tank level reader: controller states and the
// only physically possible float-sensor patterns {High, Medium, Low}.
package pkg_irrigacao;

   typedef enum logic [1:0] {
      PARTIDA  = 2'd0,
      OCIOSO   = 2'd1,
      ENCHENDO = 2'd2,
      FALHA    = 2'd3
   } estado_t;

   localparam logic [2:0] NIVEL_VAZIO = 3'b000;
   localparam logic [2:0] NIVEL_BAIXO = 3'b001;
   localparam logic [2:0] NIVEL_MEDIO = 3'b011;
   localparam logic [2:0] NIVEL_CHEIO = 3'b111;

   function automatic logic nivel_impossivel(input logic [2:0] nivel);
      return !((nivel == NIVEL_VAZIO) || (nivel == NIVEL_BAIXO) ||
               (nivel == NIVEL_MEDIO) || (nivel == NIVEL_CHEIO));
   endfunction

endpackage

// File: rtl/debounce_nivel.sv
// Debouncer for the synchronized {H,M,L} vector: tracks a candidate and flags a
// commit once it has stayed equal to the input for DEBOUNCE_CYCLES evaluations.
module debounce_nivel #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [2:0] nivel_sync,
   output logic [2:0] candidato,
   output logic       commit
);
   import pkg_irrigacao::*;

   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

   logic [2:0] cand_q, cand_d;
   logic [7:0] cnt_q, cnt_d;

   // Counter saturates at CNT_MAX, so a stable input keeps re-committing the same value.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      commit = 1'b0;
      if (en) begin
         if (nivel_sync != cand_q) begin
            cand_d = nivel_sync;
            cnt_d  = '0;
         end else if (cnt_q == CNT_MAX) begin
            commit = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q <= '0;
         cnt_q  <= '0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
      end
   end

   assign candidato = cand_q;

endmodule

// File: rtl/leitor_nivel_caixa.sv
// Tank level reader: synchronizes and debounces three float sensors and drives
// the inlet valve with a fill timeout and latched fault handling.
module leitor_nivel_caixa #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned FILL_TIMEOUT    = 64
) (
   input  logic Clock,
   input  logic Reset,
   input  logic SensorHigh,
   input  logic SensorMedium,
   input  logic SensorLow,
   output logic High,
   output logic Medium,
   output logic Low,
   output logic NivelValido,
   output logic Erro,
   output logic Alarme,
   output logic ValvulaEntrada,
   output logic Falha
);
   import pkg_irrigacao::*;

   localparam logic [15:0] TIMER_MAX = 16'(FILL_TIMEOUT - 1);

   logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]  sync_vld_q, sync_vld_d;
   logic [2:0]  nivel_q, nivel_d;
   logic        valido_q, valido_d;
   logic        erro_q, erro_d;
   logic        alarme_q, alarme_d;
   logic        valvula_q, valvula_d;
   logic        falha_q, falha_d;
   logic [15:0] timer_q, timer_d;
   estado_t     estado_q, estado_d;
   logic [2:0]  candidato;
   logic        commit;

   // Debouncer waits until the two-flop pipeline holds samples taken after reset.
   always_comb begin
      sync1_d    = {SensorHigh, SensorMedium, SensorLow};
      sync2_d    = sync1_q;
      sync_vld_d = {sync_vld_q[0], 1'b1};
   end

   debounce_nivel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk        (Clock),
      .rst        (Reset),
      .en         (sync_vld_q[1]),
      .nivel_sync (sync2_q),
      .candidato  (candidato),
      .commit     (commit)
   );

   always_comb begin
      nivel_d  = nivel_q;
      valido_d = valido_q;
      erro_d   = erro_q;
      if (commit) begin
         nivel_d  = candidato;
         valido_d = 1'b1;
         erro_d   = nivel_impossivel(candidato);
      end

      estado_d = estado_q;
      timer_d  = timer_q;
      unique case (estado_q)
         PARTIDA: if (commit) estado_d = OCIOSO;
         OCIOSO: begin
            if (erro_q) begin
               estado_d = FALHA;
            end else if (!nivel_q[1]) begin
               estado_d = ENCHENDO;
               timer_d  = '0;
            end
         end
         ENCHENDO: begin
            if (erro_q)                  estado_d = FALHA;
            else if (nivel_q[2])         estado_d = OCIOSO;
            else if (timer_q == TIMER_MAX) estado_d = FALHA;
            else                         timer_d  = timer_q + 16'd1;
         end
         FALHA: estado_d = FALHA;
      endcase

      // A fresh Erro commit closes the valve on the same edge, before FALHA is reached.
      valvula_d = (estado_d == ENCHENDO) && !erro_d;
      falha_d   = (estado_d == FALHA);
      alarme_d  = erro_d | falha_d | (valido_d & ~nivel_d[0]);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         sync_vld_q <= '0;
         nivel_q    <= '0;
         valido_q   <= 1'b0;
         erro_q     <= 1'b0;
         alarme_q   <= 1'b0;
         valvula_q  <= 1'b0;
         falha_q    <= 1'b0;
         timer_q    <= '0;
         estado_q   <= PARTIDA;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         sync_vld_q <= sync_vld_d;
         nivel_q    <= nivel_d;
         valido_q   <= valido_d;
         erro_q     <= erro_d;
         alarme_q   <= alarme_d;
         valvula_q  <= valvula_d;
         falha_q    <= falha_d;
         timer_q    <= timer_d;
         estado_q   <= estado_d;
      end
   end

   assign {High, Medium, Low} = nivel_q;
   assign NivelValido         = valido_q;
   assign Erro                = erro_q;
   assign Alarme              = alarme_q;
   assign ValvulaEntrada      = valvula_q;
   assign Falha               = falha_q;

endmodule

// File: tb/tb_leitor_nivel_caixa.sv
// Bench for leitor_nivel_caixa: sample-history model checked every cycle plus
// hand-computed expectations at key cycles.
module tb_leitor_nivel_caixa;

   localparam int DC = 4;
   localparam int FT = 64;
   localparam int M_PARTIDA  = 0;
   localparam int M_OCIOSO   = 1;
   localparam int M_ENCHENDO = 2;
   localparam int M_FALHA    = 3;

   typedef struct {
      logic [2:0] lvl;
      logic       valido;
      logic       erro;
      logic       alarme;
      logic       valv;
      logic       falha;
      int         st;
      int         entry;
   } mdl_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] raw = 3'b000;
   logic       High, Medium, Low, NivelValido, Erro, Alarme, ValvulaEntrada, Falha;

   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   logic       armed = 1'b0;
   logic [2:0] hist[$];
   mdl_t       m;

   always #5 clk = ~clk;

   leitor_nivel_caixa #(.DEBOUNCE_CYCLES(DC), .FILL_TIMEOUT(FT)) dut (
      .Clock          (clk),
      .Reset          (rst),
      .SensorHigh     (raw[2]),
      .SensorMedium   (raw[1]),
      .SensorLow      (raw[0]),
      .High           (High),
      .Medium         (Medium),
      .Low            (Low),
      .NivelValido    (NivelValido),
      .Erro           (Erro),
      .Alarme         (Alarme),
      .ValvulaEntrada (ValvulaEntrada),
      .Falha          (Falha)
   );

   function automatic mdl_t model_reset();
      mdl_t r;
      r.lvl = 3'b000; r.valido = 1'b0; r.erro = 1'b0; r.alarme = 1'b0;
      r.valv = 1'b0; r.falha = 1'b0; r.st = M_PARTIDA; r.entry = 0;
      return r;
   endfunction

   // hist[k] is the raw vector sampled at edge k after reset (hist[0] = reset value).
   // A level commits at edge c when hist[c-2-DC .. c-2] are all equal.
   function automatic mdl_t model_step(input mdl_t o, input int c);
      mdl_t       n;
      logic       cm;
      logic [2:0] v;
      n  = o;
      cm = 1'b0;
      v  = 3'b000;
      if (c >= 2 + DC) begin
         v  = hist[c-2-DC];
         cm = 1'b1;
         for (int k = c - 1 - DC; k <= c - 2; k++)
            if (hist[k] != v) cm = 1'b0;
      end
      if (cm) begin
         n.lvl    = v;
         n.valido = 1'b1;
         n.erro   = (v[2] & ~v[1]) | (v[1] & ~v[0]);
      end
      if (o.st == M_PARTIDA) begin
         if (cm) n.st = M_OCIOSO;
      end else if (o.st == M_OCIOSO) begin
         if (o.erro) n.st = M_FALHA;
         else if (!o.lvl[1]) begin
            n.st    = M_ENCHENDO;
            n.entry = c;
         end
      end else if (o.st == M_ENCHENDO) begin
         if (o.erro)               n.st = M_FALHA;
         else if (o.lvl[2])        n.st = M_OCIOSO;
         else if (c - o.entry == FT) n.st = M_FALHA;
      end
      n.falha  = (n.st == M_FALHA);
      n.valv   = (n.st == M_ENCHENDO) && !n.erro;
      n.alarme = n.erro | n.falha | (n.valido & ~n.lvl[0]);
      return n;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         hist.delete();
         hist.push_back(3'b000);
         cyc <= 0;
         m   <= model_reset();
      end else begin
         m <= model_step(m, cyc + 1);
         hist.push_back(raw);
         cyc <= cyc + 1;
      end
   end

   function automatic void chk(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (armed) begin
         chk("High", High, m.lvl[2]);
         chk("Medium", Medium, m.lvl[1]);
         chk("Low", Low, m.lvl[0]);
         chk("NivelValido", NivelValido, m.valido);
         chk("Erro", Erro, m.erro);
         chk("Alarme", Alarme, m.alarme);
         chk("ValvulaEntrada", ValvulaEntrada, m.valv);
         chk("Falha", Falha, m.falha);
         chk("valvula_exclusiva", ValvulaEntrada & (Erro | Falha), 1'b0);
      end
   end

   task automatic wait_to(input int n);
      for (int i = 0; i < 400 && cyc != n; i++) @(negedge clk);
      total++;
      if (cyc != n) begin
         bad++;
         $display("FAIL wait_to cyc=%0d want=%0d", cyc, n);
      end
   endtask

   task automatic do_reset(input logic [2:0] v);
      rst = 1'b1;
      raw = v;
      @(negedge clk);
      rst   = 1'b0;
      armed = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      // Power-up fill from empty, then staged refill and glitch rejection.
      do_reset(3'b000);
      chk("rst_High", High, 1'b0);
      chk("rst_NivelValido", NivelValido, 1'b0);
      chk("rst_Alarme", Alarme, 1'b0);
      chk("rst_Valvula", ValvulaEntrada, 1'b0);
      chk("rst_Falha", Falha, 1'b0);
      wait_to(5);  chk("a5_valido", NivelValido, 1'b0);
      wait_to(6);  chk("a6_valido", NivelValido, 1'b1);
                   chk("a6_model_valido", m.valido, 1'b1);
                   chk("a6_alarme", Alarme, 1'b1);
                   chk("a6_valvula", ValvulaEntrada, 1'b0);
      wait_to(7);  chk("a7_valvula", ValvulaEntrada, 1'b1);
                   chk("a7_model_valv", m.valv, 1'b1);
      wait_to(10); raw = 3'b001;
      wait_to(16); chk("a16_low", Low, 1'b0);
      wait_to(17); chk("a17_low", Low, 1'b1);
                   chk("a17_alarme", Alarme, 1'b0);
      wait_to(20); raw = 3'b011;
      wait_to(27); chk("a27_medium", Medium, 1'b1);
                   chk("a27_valvula", ValvulaEntrada, 1'b1);
      wait_to(30); raw = 3'b111;
      wait_to(36); chk("a36_high", High, 1'b0);
      wait_to(37); chk("a37_high", High, 1'b1);
                   chk("a37_valvula", ValvulaEntrada, 1'b1);
      wait_to(38); chk("a38_valvula", ValvulaEntrada, 1'b0);
      wait_to(45); raw = 3'b011;
      wait_to(47); raw = 3'b111;
      for (int k = 48; k <= 60; k++) begin
         wait_to(k);
         chk("glitch_high", High, 1'b1);
         chk("glitch_valvula", ValvulaEntrada, 1'b0);
      end
      raw = 3'b011;
      wait_to(67); chk("a67_high", High, 1'b0);
                   chk("a67_medium", Medium, 1'b1);
      wait_to(68); chk("a68_valvula", ValvulaEntrada, 1'b0);
      wait_to(70); raw = 3'b001;
      wait_to(77); chk("a77_medium", Medium, 1'b0);
                   chk("a77_valvula", ValvulaEntrada, 1'b0);
      wait_to(78); chk("a78_valvula", ValvulaEntrada, 1'b1);
      wait_to(141); chk("a141_valvula", ValvulaEntrada, 1'b1);
                    chk("a141_falha", Falha, 1'b0);
      wait_to(142); chk("a142_falha", Falha, 1'b1);
                    chk("a142_model_falha", m.falha, 1'b1);
                    chk("a142_valvula", ValvulaEntrada, 1'b0);
                    chk("a142_alarme", Alarme, 1'b1);
      wait_to(150); raw = 3'b111;
      wait_to(170); chk("a170_high", High, 1'b1);
                    chk("a170_falha", Falha, 1'b1);
                    chk("a170_valvula", ValvulaEntrada, 1'b0);

      // Reset in the middle of a fill with a half-debounced change pending.
      do_reset(3'b000);
      chk("b0_falha", Falha, 1'b0);
      wait_to(7);  chk("b7_valvula", ValvulaEntrada, 1'b1);
      wait_to(12); raw = 3'b001;
      wait_to(15);
      do_reset(3'b000);
      chk("r_high", High, 1'b0);
      chk("r_medium", Medium, 1'b0);
      chk("r_low", Low, 1'b0);
      chk("r_valido", NivelValido, 1'b0);
      chk("r_erro", Erro, 1'b0);
      chk("r_alarme", Alarme, 1'b0);
      chk("r_valvula", ValvulaEntrada, 1'b0);
      chk("r_falha", Falha, 1'b0);
      wait_to(5);  chk("r5_valido", NivelValido, 1'b0);
      wait_to(6);  chk("r6_valido", NivelValido, 1'b1);
                   chk("r6_low", Low, 1'b0);
      wait_to(7);  chk("r7_valvula", ValvulaEntrada, 1'b1);

      // High commits on the same cycle the fill timer expires: refill stops, no fault.
      wait_to(63); raw = 3'b111;
      wait_to(70); chk("c70_high", High, 1'b1);
                   chk("c70_valvula", ValvulaEntrada, 1'b1);
      wait_to(71); chk("c71_valvula", ValvulaEntrada, 1'b0);
                   chk("c71_falha", Falha, 1'b0);
      wait_to(72); chk("c72_falha", Falha, 1'b0);
                   chk("c72_model_st", m.st == M_OCIOSO, 1'b1);

      // Impossible pattern appears while filling.
      do_reset(3'b000);
      wait_to(7);  chk("d7_valvula", ValvulaEntrada, 1'b1);
      wait_to(10); raw = 3'b101;
      wait_to(16); chk("d16_valvula", ValvulaEntrada, 1'b1);
                   chk("d16_erro", Erro, 1'b0);
      wait_to(17); chk("d17_erro", Erro, 1'b1);
                   chk("d17_valvula", ValvulaEntrada, 1'b0);
                   chk("d17_falha", Falha, 1'b0);
                   chk("d17_alarme", Alarme, 1'b1);
      wait_to(18); chk("d18_falha", Falha, 1'b1);
                   chk("d18_valvula", ValvulaEntrada, 1'b0);
      wait_to(25); chk("d25_falha", Falha, 1'b1);

      // Impossible pattern present from reset onward.
      do_reset(3'b101);
      wait_to(6);  chk("e6_erro", Erro, 1'b0);
                   chk("e6_valido", NivelValido, 1'b0);
      wait_to(7);  chk("e7_erro", Erro, 1'b1);
                   chk("e7_valido", NivelValido, 1'b1);
                   chk("e7_falha", Falha, 1'b0);
      wait_to(8);  chk("e8_falha", Falha, 1'b1);
      wait_to(12); chk("e12_valvula", ValvulaEntrada, 1'b0);

      armed = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      total++;
      $display("FAIL watchdog cyc=%0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/leitor_nivel_caixa.md
LEITOR_NIVEL_CAIXA -- requirements
Module: leitor_nivel_caixa

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive stable synchronized samples required before a new level is committed; legal range 2..255.
REQ-002 Parameter FILL_TIMEOUT, default 64: maximum cycles in ENCHENDO without reaching High before FALHA; legal range 8..65535.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 SensorHigh, SensorMedium, SensorLow  input  1 each  raw asynchronous tank float sensors; 1 means water at that level.
REQ-006 High, Medium, Low  output  1 each  debounced, committed sensor levels.
REQ-007 NivelValido  output  1  1 once at least one level has been committed since reset.
REQ-008 Erro  output  1  committed pattern is physically impossible.
REQ-009 Alarme  output  1  Erro, low tank, or latched fill fault.
REQ-010 ValvulaEntrada  output  1  inlet valve drive; 1 means filling.
REQ-011 Falha  output  1  latched fill-timeout or error fault.

Function
REQ-012 Each raw sensor SHALL pass through its own two-flop synchronizer before any other use.
REQ-013 The debouncer SHALL hold a 3-bit candidate {H,M,L} and a stability counter, and SHALL reload the candidate and zero the counter whenever the synchronized vector differs from the candidate.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 with the synchronized vector equal to the candidate, the candidate SHALL be committed to High/Medium/Low on the next edge, and NivelValido SHALL be set.
REQ-015 A raw change held stable SHALL appear on High/Medium/Low exactly 2+DEBOUNCE_CYCLES cycles after the first edge that samples it; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never reach the outputs.
REQ-016 A committed value identical to the current committed value SHALL cause no output change.
REQ-017 Erro SHALL equal (High AND NOT Medium) OR (Medium AND NOT Low), evaluated on committed values, registered together with the commit.
REQ-018 The FSM SHALL have states PARTIDA, OCIOSO, ENCHENDO and FALHA.
REQ-019 PARTIDA: ValvulaEntrada=0; transition to OCIOSO on the first commit.
REQ-020 OCIOSO: ValvulaEntrada=0; transition to ENCHENDO when committed Medium=0 and Erro=0.
REQ-021 ENCHENDO: ValvulaEntrada=1; fill timer counts up from 0 on entry; transition to OCIOSO when committed High=1 and Erro=0 (hysteresis: refill restarts only below Medium).
REQ-022 ENCHENDO: transition to FALHA when the fill timer reaches FILL_TIMEOUT-1 without High=1; High and timeout in the same cycle SHALL resolve to OCIOSO.
REQ-023 Erro=1 in OCIOSO or ENCHENDO SHALL transition to FALHA on the next edge, with priority over all other transitions.
REQ-024 FALHA: ValvulaEntrada=0, Falha=1; exit only through Reset.
REQ-025 Alarme SHALL equal Erro OR Falha OR (NivelValido AND NOT Low), registered.
REQ-026 ValvulaEntrada SHALL never be 1 in the same cycle as Erro=1 or Falha=1.

Reset
REQ-027 Reset SHALL set synchronizers, candidate, committed levels and counters to 0; NivelValido, Erro, Alarme, Falha and ValvulaEntrada to 0; FSM to PARTIDA.
REQ-028 Reset asserted mid-fill SHALL drop ValvulaEntrada on the same edge and discard all in-progress debounce state.

Structure
REQ-029 FSM state encoding and the legal-pattern constants (000, 001, 011, 111) SHALL live in a shared package, pkg_irrigacao.
REQ-030 The per-vector debouncer SHALL be a separate sub-module, debounce_nivel, parameterized by DEBOUNCE_CYCLES; the synchronizer and FSM SHALL remain in the top module.

Verification (DEBOUNCE_CYCLES=4, FILL_TIMEOUT=64)
REQ-031 Reset, then hold raw 000 -> NivelValido=1 and ValvulaEntrada=1 follow the commit at cycle 6; Alarme=1 (Low=0).
REQ-032 From 111 committed, 2-cycle raw pulse to 011 -> High stays 1, no commit, ValvulaEntrada stays 0.
REQ-033 From ENCHENDO, drive raw 001, 011, 111, each held for 10 cycles -> ValvulaEntrada falls the cycle after High commits; the FSM stays in OCIOSO until Medium commits 0.
REQ-034 Raw 001 held for 70 cycles from ENCHENDO entry -> Falha=1 and ValvulaEntrada=0 at fill timer 63; both remain so after raw 111 until Reset.
REQ-035 Raw 101 stable -> Erro=1 at commit, FALHA on the next edge, ValvulaEntrada=0 throughout.
REQ-036 Reset pulsed during ENCHENDO -> all outputs 0 on that edge; the FSM re-enters PARTIDA and the commit is repeated after 6 cycles.
